// File: rtl/trace_request_queue.sv
// Trace command queue feeding a cache controller through a registered request stage.
// Define TRQ_STATS_EN to build the read/write/snoop handshake counters; otherwise they read 0.
module trace_request_queue #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 8,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [3:0]                         cmd_code,
  input  logic [ADDR_W-1:0]                  cmd_addr,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic [2:0]                         req_op,
  output logic                               req_snoop,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] req_tag,
  output logic [INDEX_W-1:0]                 req_index,
  output logic [OFFSET_W-1:0]                req_offset,
  input  logic                               ctrl_busy,
  output logic                               clear_pulse,
  output logic                               print_pulse,
  output logic                               bad_cmd,
  output logic [31:0]                        rd_cnt,
  output logic [31:0]                        wr_cnt,
  output logic [31:0]                        snoop_cnt
);

  // state     | meaning
  // RUN       | stream codes 0-6 from the FIFO head into the request register
  // CTRL_WAIT | code 8/9 at head; wait for request register empty and controller idle
  // CTRL_FIRE | clear/print strobe high this cycle; head popped at the next edge

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] OCC_FULL = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, CTRL_WAIT, CTRL_FIRE} state_t;

  state_t            state;
  logic [3:0]        code_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic [3:0]        head_code;
  logic [ADDR_W-1:0] head_addr;
  logic              cmd_legal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              head_req;
  logic              head_ctrl;
  logic              load;
  logic              fire_ok;

  // The presented request counts against capacity, so DEPTH commands in total can be held.
  assign occ        = {1'b0, count} + {{CNT_W{1'b0}}, req_valid};
  assign cmd_ready  = (occ < OCC_FULL);
  assign cmd_legal  = (cmd_code <= 4'd6) || (cmd_code == 4'd8) || (cmd_code == 4'd9);
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && cmd_legal;
  assign fifo_empty = (count == '0);
  assign head_code  = code_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign head_req   = !fifo_empty && !head_code[3];
  assign head_ctrl  = !fifo_empty && head_code[3];
  assign load       = (state == RUN) && head_req && (!req_valid || req_ready);
  assign fire_ok    = (state == CTRL_WAIT) && !req_valid && !ctrl_busy;
  assign pop        = load || (state == CTRL_FIRE);

  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr] <= cmd_code;
      addr_mem[wr_ptr] <= cmd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      bad_cmd <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && !cmd_legal) bad_cmd <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      req_valid   <= 1'b0;
      req_op      <= '0;
      req_snoop   <= 1'b0;
      req_tag     <= '0;
      req_index   <= '0;
      req_offset  <= '0;
      clear_pulse <= 1'b0;
      print_pulse <= 1'b0;
    end else begin
      clear_pulse <= 1'b0;
      print_pulse <= 1'b0;
      if (load) begin
        req_valid  <= 1'b1;
        req_op     <= head_code[2:0];
        req_snoop  <= (head_code[2:0] >= 3'd3);
        req_tag    <= head_addr[ADDR_W-1 -: TAG_W];
        req_index  <= head_addr[OFFSET_W +: INDEX_W];
        req_offset <= head_addr[OFFSET_W-1:0];
      end else if (req_ready) begin
        req_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (head_ctrl) state <= CTRL_WAIT;
        end
        CTRL_WAIT: begin
          if (fire_ok) begin
            state       <= CTRL_FIRE;
            clear_pulse <= !head_code[0];
            print_pulse <= head_code[0];
          end
        end
        CTRL_FIRE: state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

`ifdef TRQ_STATS_EN
  logic hs;
  logic clear_now;

  assign hs        = req_valid && req_ready;
  // Counters clear on the same edge that raises clear_pulse; no handshake can coincide with it.
  assign clear_now = fire_ok && !head_code[0];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      snoop_cnt <= '0;
    end else if (clear_now) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      snoop_cnt <= '0;
    end else if (hs) begin
      if (req_snoop)           snoop_cnt <= sat_inc(snoop_cnt);
      else if (req_op == 3'd1) wr_cnt    <= sat_inc(wr_cnt);
      else                     rd_cnt    <= sat_inc(rd_cnt);
    end
  end
`else
  assign rd_cnt    = '0;
  assign wr_cnt    = '0;
  assign snoop_cnt = '0;
`endif

endmodule

// File: tb/tb_trace_request_queue.sv
// Directed bench for trace_request_queue; counter expectations follow TRQ_STATS_EN.
module tb_trace_request_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_snoop;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        ctrl_busy;
  logic        clear_pulse;
  logic        print_pulse;
  logic        bad_cmd;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] snoop_cnt;

`ifdef TRQ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  trace_request_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_code    (cmd_code),
    .cmd_addr    (cmd_addr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_snoop   (req_snoop),
    .req_tag     (req_tag),
    .req_index   (req_index),
    .req_offset  (req_offset),
    .ctrl_busy   (ctrl_busy),
    .clear_pulse (clear_pulse),
    .print_pulse (print_pulse),
    .bad_cmd     (bad_cmd),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .snoop_cnt   (snoop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 4'd0;
    cmd_addr  = 32'd0;
    req_ready = 1'b0;
    ctrl_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic put(input logic [3:0] c, input logic [31:0] a);
    cmd_valid = 1'b1;
    cmd_code  = c;
    cmd_addr  = a;
    chk("put_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] faddr(input int k);
    return {12'hABC, 14'(k + 1), 6'(k)};
  endfunction

  function automatic logic [3:0] fcode(input int k);
    return 4'(k % 7);
  endfunction

  initial begin
    int issued;
    bit accept_now;
    bit found;

    // reset values, sampled while rst_n is low
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 4'd0; cmd_addr = 32'd0;
    req_ready = 1'b0; ctrl_busy = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready",  64'(cmd_ready),   64'd1);
    chk("rst_req_valid",  64'(req_valid),   64'd0);
    chk("rst_req_op",     64'(req_op),      64'd0);
    chk("rst_req_snoop",  64'(req_snoop),   64'd0);
    chk("rst_req_tag",    64'(req_tag),     64'd0);
    chk("rst_req_index",  64'(req_index),   64'd0);
    chk("rst_req_offset", 64'(req_offset),  64'd0);
    chk("rst_clear",      64'(clear_pulse), 64'd0);
    chk("rst_print",      64'(print_pulse), 64'd0);
    chk("rst_bad_cmd",    64'(bad_cmd),     64'd0);
    chk("rst_rd_cnt",     64'(rd_cnt),      64'd0);
    chk("rst_wr_cnt",     64'(wr_cnt),      64'd0);
    chk("rst_snoop_cnt",  64'(snoop_cnt),   64'd0);
    rst_n = 1'b1;
    tick();

    // single read: registered output appears one edge after acceptance
    put(4'd0, 32'h1234_5678);
    chk("t1_not_yet_valid", 64'(req_valid), 64'd0);
    tick();
    chk("t1_valid",  64'(req_valid),  64'd1);
    chk("t1_op",     64'(req_op),     64'd0);
    chk("t1_tag",    64'(req_tag),    64'h123);
    chk("t1_index",  64'(req_index),  64'h1159);
    chk("t1_offset", 64'(req_offset), 64'h38);
    chk("t1_snoop",  64'(req_snoop),  64'd0);
    req_ready = 1'b1;
    tick();
    chk("t1_consumed", 64'(req_valid), 64'd0);
    req_ready = 1'b0;

    // fill with req_ready low: 8 accepted then stall
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cmd_valid = 1'b1;
      cmd_code  = fcode(k);
      cmd_addr  = faddr(k);
      chk("fill_ready", 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_code = fcode(8);
    cmd_addr = faddr(8);
    chk("fill_full",      64'(cmd_ready), 64'd0);
    chk("fill_presented", 64'(req_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fill_stall_ready",  64'(cmd_ready),  64'd0);
      chk("fill_stable_valid", 64'(req_valid),  64'd1);
      chk("fill_stable_op",    64'(req_op),     64'(fcode(0)));
      chk("fill_stable_tag",   64'(req_tag),    64'hABC);
      chk("fill_stable_index", 64'(req_index),  64'd1);
      chk("fill_stable_off",   64'(req_offset), 64'd0);
    end
    req_ready = 1'b1;
    issued = 0;
    for (int c = 0; c < 30 && issued < 9; c++) begin
      accept_now = cmd_valid && cmd_ready;
      if (req_valid) begin
        chk("fill_order_op",    64'(req_op),     64'(fcode(issued)));
        chk("fill_order_index", 64'(req_index),  64'(issued + 1));
        chk("fill_order_off",   64'(req_offset), 64'(issued));
        issued++;
      end
      tick();
      if (accept_now) cmd_valid = 1'b0;
    end
    chk("fill_issued", 64'(issued), 64'd9);
    tick();
    chk("fill_drained_valid", 64'(req_valid), 64'd0);
    chk("fill_drained_ready", 64'(cmd_ready), 64'd1);
    req_ready = 1'b0;

    // write, clear, snoop with controller busy
    do_reset();
    req_ready = 1'b1;
    ctrl_busy = 1'b1;
    cmd_valid = 1'b1; cmd_code = 4'd1; cmd_addr = 32'h0000_0040;
    tick();
    cmd_code = 4'd8; cmd_addr = 32'h0;
    tick();
    chk("ctrl_c1_valid", 64'(req_valid), 64'd1);
    chk("ctrl_c1_op",    64'(req_op),    64'd1);
    cmd_code = 4'd4; cmd_addr = 32'h0000_0080;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ctrl_busy_no_clear", 64'(clear_pulse), 64'd0);
      chk("ctrl_busy_held",     64'(req_valid),   64'd0);
      if (i == 4) ctrl_busy = 1'b0;
      tick();
    end
    chk("ctrl_clear_fire", 64'(clear_pulse), 64'd1);
    chk("ctrl_no_print",   64'(print_pulse), 64'd0);
    chk("ctrl_c4_waits",   64'(req_valid),   64'd0);
    tick();
    chk("ctrl_clear_once", 64'(clear_pulse), 64'd0);
    chk("ctrl_c4_pending", 64'(req_valid),   64'd0);
    tick();
    chk("ctrl_c4_valid", 64'(req_valid), 64'd1);
    chk("ctrl_c4_op",    64'(req_op),    64'd4);
    chk("ctrl_c4_snoop", 64'(req_snoop), 64'd1);
    chk("ctrl_c4_index", 64'(req_index), 64'd2);
    tick();
    chk("ctrl_c4_done", 64'(req_valid), 64'd0);
    put(4'd9, 32'h0);
    tick();
    chk("print_not_yet", 64'(print_pulse), 64'd0);
    tick();
    chk("print_fire",     64'(print_pulse), 64'd1);
    chk("print_no_clear", 64'(clear_pulse), 64'd0);
    tick();
    chk("print_once", 64'(print_pulse), 64'd0);

    // illegal codes: accepted, dropped, sticky bad_cmd
    do_reset();
    cmd_code = 4'd7; cmd_addr = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("idle_bad_ignored",   64'(bad_cmd),   64'd0);
    chk("idle_no_req",        64'(req_valid), 64'd0);
    put(4'd7, 32'h0000_1000);
    chk("bad7_flag", 64'(bad_cmd), 64'd1);
    tick();
    tick();
    chk("bad7_no_req",   64'(req_valid), 64'd0);
    chk("bad7_sticky",   64'(bad_cmd),   64'd1);
    chk("bad7_ready",    64'(cmd_ready), 64'd1);
    put(4'd12, 32'h0);
    tick();
    tick();
    chk("bad12_no_req", 64'(req_valid), 64'd0);
    do_reset();
    chk("bad_cleared_by_reset", 64'(bad_cmd), 64'd0);

    // statistics: 3 reads, 2 writes, 1 snoop, then clear
    do_reset();
    req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1;
      case (k)
        0: cmd_code = 4'd0;
        1: cmd_code = 4'd2;
        2: cmd_code = 4'd0;
        3: cmd_code = 4'd1;
        4: cmd_code = 4'd1;
        default: cmd_code = 4'd5;
      endcase
      cmd_addr = 32'(k) << 6;
      chk("stats_ready", 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("stats_rd",    64'(rd_cnt),    64'(3 * STATS));
    chk("stats_wr",    64'(wr_cnt),    64'(2 * STATS));
    chk("stats_snoop", 64'(snoop_cnt), 64'(1 * STATS));
    put(4'd8, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (clear_pulse) found = 1'b1;
      else tick();
    end
    chk("stats_clear_seen",  64'(found),     64'd1);
    chk("stats_rd_clr",      64'(rd_cnt),    64'd0);
    chk("stats_wr_clr",      64'(wr_cnt),    64'd0);
    chk("stats_snoop_clr",   64'(snoop_cnt), 64'd0);
    tick();
    chk("stats_rd_stay0",    64'(rd_cnt),    64'd0);

    // reset asserted mid-operation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1;
      cmd_code  = fcode(k);
      cmd_addr  = faddr(k);
      tick();
    end
    cmd_valid = 1'b0;
    chk("mid_valid_before", 64'(req_valid), 64'd1);
    chk("mid_index_before", 64'(req_index), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(req_valid),   64'd0);
    chk("mid_rst_ready", 64'(cmd_ready),   64'd1);
    chk("mid_rst_index", 64'(req_index),   64'd0);
    chk("mid_rst_clear", 64'(clear_pulse), 64'd0);
    chk("mid_rst_print", 64'(print_pulse), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_after_valid", 64'(req_valid), 64'd0);
    chk("mid_after_ready", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_request_queue.md
TRACE_REQUEST_QUEUE -- requirements
Module: trace_request_queue

Interface
REQ-001 Parameter ADDR_W, default 32: trace address width.
REQ-002 Parameter DEPTH, default 8: command FIFO entries, power of two, at least 2.
REQ-003 Parameter OFFSET_W, default 6: line offset bits.
REQ-004 Parameter INDEX_W, default 14: set index bits; tag width SHALL be ADDR_W-INDEX_W-OFFSET_W.
REQ-005 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  trace command offered by the trace reader.
REQ-008 cmd_ready  out  1  queue accepts the offered command this cycle.
REQ-009 cmd_code  in  4  trace code 0-9.
REQ-010 cmd_addr  in  ADDR_W  trace address.
REQ-011 req_valid  out  1  request offered to the cache controller.
REQ-012 req_ready  in  1  controller takes the request.
REQ-013 req_op  out  3  trace code 0-6, passed unchanged.
REQ-014 req_snoop  out  1  high for codes 3-6.
REQ-015 req_tag / req_index / req_offset  out  tag width / INDEX_W / OFFSET_W  address fields, MSB to LSB.
REQ-016 ctrl_busy  in  1  controller has a transaction in flight.
REQ-017 clear_pulse / print_pulse  out  1 each  one-cycle strobes for codes 8 and 9.
REQ-018 bad_cmd  out  1  sticky flag: an illegal code was received.
REQ-019 rd_cnt, wr_cnt, snoop_cnt  out  32 each  statistics counters (see Configuration).

Function
REQ-020 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; cmd_ready SHALL be !full, with no bypass when full.
REQ-021 Codes 0-6, 8 and 9 SHALL be enqueued; codes 7 and 10-15 SHALL be accepted, dropped, and SHALL set bad_cmd.
REQ-022 Simultaneous push and pop SHALL keep the occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 The output stage SHALL be a register: a code 0-6 accepted into an empty queue at edge N SHALL present req_valid after edge N+1.
REQ-024 While req_valid is high without req_ready, all req_* outputs SHALL remain stable; back-to-back handshakes SHALL sustain one request per cycle.
REQ-025 FSM states: RUN, CTRL_WAIT, CTRL_FIRE.
REQ-026 RUN: if the FIFO head is code 0-6, it SHALL be moved into the output register when that register is empty or being consumed; if the head is code 8 or 9, go to CTRL_WAIT.
REQ-027 CTRL_WAIT: hold the head; when req_valid and ctrl_busy are both low, go to CTRL_FIRE.
REQ-028 CTRL_FIRE: assert clear_pulse (code 8) or print_pulse (code 9) for exactly one cycle, pop the head, and return to RUN.
REQ-029 Requests queued behind a code 8 or 9 SHALL NOT issue until its pulse has fired, so trace order is preserved.
REQ-030 When cmd_valid is low, cmd_code and cmd_addr SHALL be ignored.

Reset
REQ-031 While rst_n is low, the queue SHALL be empty, state RUN, and outputs as follows: cmd_ready=1, req_valid=0, req_* payload=0, both pulses 0, bad_cmd=0, counters 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and presented requests immediately, with no pulse emitted.

Configuration
REQ-033 Macro TRQ_STATS_EN.
REQ-034 When TRQ_STATS_EN is defined, counters SHALL increment on each completed req handshake:
- rd_cnt for codes 0 and 2
- wr_cnt for code 1
- snoop_cnt for codes 3-6
REQ-035 When TRQ_STATS_EN is defined, counters SHALL saturate at all-ones and SHALL clear in the cycle clear_pulse fires.
REQ-036 When TRQ_STATS_EN is undefined, counter ports SHALL remain present and SHALL be tied to 0, with no counter flops.

Verification
REQ-037 Bench SHALL cover:
- Code 0 at address 0x1234_5678 into an empty queue -> next cycle req_valid=1, req_op=0, tag=0x123, index=0x1159, offset=0x38, req_snoop=0.
- req_ready held low, 9 commands offered with DEPTH=8 -> cmd_ready low after 8 accepted (7 in FIFO + 1 presented); payload stable; all 9 issued in order once req_ready rises.
- Code 1, then code 8, then code 4, with ctrl_busy high 5 cycles -> code 1 issues; clear_pulse fires one cycle after ctrl_busy falls; code 4 issues only after that.
- Code 7 offered -> accepted, no req_valid, bad_cmd=1 until reset.
- TRQ_STATS_EN defined, 3 reads, 2 writes, 1 snoop handshaken -> rd_cnt=3, wr_cnt=2, snoop_cnt=1; a code 8 then clears all three to 0.
- rst_n pulsed low with 4 entries queued and req_valid high -> req_valid=0 and cmd_ready=1 immediately, no pulse.
